// File: rtl/r8mbe_pkg.sv
// Shared types and sizing helpers for the radix-8 Booth sequential multiplier.
package r8mbe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_ITER,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        SEL_0,
        SEL_X,
        SEL_2X,
        SEL_3X,
        SEL_4X
    } bsel_t;

    // One spare bit keeps unsigned operands non-negative; round up to whole digits.
    function automatic int digit_count(input int width);
        return (width + 3) / 3;
    endfunction

endpackage

// File: rtl/r8mbe_seq_mult_digit_enc.sv
// Radix-8 Booth recoder: 4-bit window {y[3i+2], y[3i+1], y[3i], y[3i-1]} to magnitude select and sign.
module r8mbe_seq_mult_digit_enc
    import r8mbe_pkg::*;
(
    input  logic [3:0] win,
    output bsel_t      sel,
    output logic       neg
);

    always_comb begin
        sel = SEL_0;
        neg = 1'b0;
        case (win)
            4'b0001, 4'b0010: sel = SEL_X;
            4'b0011, 4'b0100: sel = SEL_2X;
            4'b0101, 4'b0110: sel = SEL_3X;
            4'b0111:          sel = SEL_4X;
            4'b1000:          begin sel = SEL_4X; neg = 1'b1; end
            4'b1001, 4'b1010: begin sel = SEL_3X; neg = 1'b1; end
            4'b1011, 4'b1100: begin sel = SEL_2X; neg = 1'b1; end
            4'b1101, 4'b1110: begin sel = SEL_X;  neg = 1'b1; end
            default:          begin sel = SEL_0;  neg = 1'b0; end
        endcase
    end

endmodule

// File: rtl/r8mbe_seq_mult.sv
// Iterative radix-8 Modified Booth multiplier: one Booth digit per clock, 3X precomputed once,
// valid/ready handshakes on both sides.
module r8mbe_seq_mult
    import r8mbe_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

    localparam int ND = digit_count(WIDTH);
    localparam int EW = 3 * ND;
    localparam int AW = 2 * EW;
    localparam int CW = $clog2(ND);

    state_t state, state_next;

    logic [EW-1:0]   x_reg, y_reg;
    logic [EW+1:0]   x3;
    logic [AW-1:0]   acc, acc_next;
    logic [CW-1:0]   cnt;
    logic [EW-1:0]   x_ext, y_ext;
    logic            accept, last_digit;

    logic [EW:0]     yw;
    logic [3:0]      win_arr [ND];
    logic [3:0]      win;
    bsel_t           sel;
    logic            neg;
    logic [EW+1:0]   mult;
    logic [AW-1:0]   mult_ext, pp;
    logic [CW+1:0]   shamt;

    assign x_ext = in_signed ? {{(EW-WIDTH){in_x[WIDTH-1]}}, in_x} : {{(EW-WIDTH){1'b0}}, in_x};
    assign y_ext = in_signed ? {{(EW-WIDTH){in_y[WIDTH-1]}}, in_y} : {{(EW-WIDTH){1'b0}}, in_y};

    assign accept     = in_valid & in_ready;
    assign last_digit = (cnt == CW'(ND - 1));
    assign out_valid  = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // In DONE the input side follows out_ready so a new operand pair can load on the draining edge.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_PRE;
            end
            ST_PRE:  state_next = ST_ITER;
            ST_ITER: if (last_digit) state_next = ST_DONE;
            ST_DONE: begin
                in_ready = out_ready;
                if (out_ready) state_next = in_valid ? ST_PRE : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // y[-1] is the implicit zero below the LSB digit.
    assign yw = {y_reg, 1'b0};

    for (genvar i = 0; i < ND; i++) begin : g_win
        assign win_arr[i] = yw[3*i +: 4];
    end

    assign win = win_arr[cnt];

    r8mbe_seq_mult_digit_enc u_enc (
        .win (win),
        .sel (sel),
        .neg (neg)
    );

    always_comb begin
        mult = '0;
        case (sel)
            SEL_X:   mult = {{2{x_reg[EW-1]}}, x_reg};
            SEL_2X:  mult = {x_reg[EW-1], x_reg, 1'b0};
            SEL_3X:  mult = x3;
            SEL_4X:  mult = {x_reg, 2'b00};
            default: mult = '0;
        endcase
    end

    assign mult_ext = {{(AW-EW-2){mult[EW+1]}}, mult};
    assign pp       = neg ? (~mult_ext + AW'(1)) : mult_ext;
    assign shamt    = {1'b0, cnt, 1'b0} + {2'b00, cnt};
    assign acc_next = acc + (pp << shamt);

    // Operands are extended once at capture; out_p only moves when a finished product lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg <= '0;
            y_reg <= '0;
            x3    <= '0;
            acc   <= '0;
            cnt   <= '0;
            out_p <= '0;
        end else begin
            if (accept) begin
                x_reg <= x_ext;
                y_reg <= y_ext;
                acc   <= '0;
                cnt   <= '0;
            end
            if (state == ST_PRE) begin
                x3 <= {x_reg[EW-1], x_reg, 1'b0} + {{2{x_reg[EW-1]}}, x_reg};
            end
            if (state == ST_ITER) begin
                acc <= acc_next;
                cnt <= cnt + CW'(1);
                if (last_digit) out_p <= acc_next[2*WIDTH-1:0];
            end
        end
    end

endmodule
